// File: rtl/param_bus_writer.sv
// Parses A5/SEL/DATA/CHK frames from the UART receiver and plays each accepted command onto the
// en/sel/data parameter bus as one timed load/hold/commit cycle. Define ACK_TX_EN for the ack byte port.
module param_bus_writer #(
  parameter logic [7:0] HDR_BYTE    = 8'hA5,
  parameter int         SETUP_CYC   = 4,
  parameter int         HOLD_CYC    = 2,
  parameter int         COMMIT_CYC  = 2,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       bus_en,
  output logic [2:0] bus_sel,
  output logic [7:0] bus_data,
  output logic       busy,
  output logic [7:0] err_cnt,
  output logic [7:0] drop_cnt
`ifdef ACK_TX_EN
  ,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {P_HUNT, P_GOT_H, P_GOT_S, P_GOT_D} pstate_t;
  typedef enum logic [2:0] {B_IDLE, B_PRE, B_LOAD, B_HOLD, B_COMMIT} bstate_t;

  pstate_t       pstate_q, pstate_d;
  logic [7:0]    sel_q, sel_d, data_q, data_d;
  logic [TW-1:0] idle_q, idle_d;
  bstate_t       bstate_q, bstate_d;
  logic [7:0]    phase_q, phase_d;
  logic          pend_v_q, pend_v_d;
  logic [2:0]    pend_sel_q, pend_sel_d, cmd_sel_q, cmd_sel_d;
  logic [7:0]    pend_data_q, pend_data_d, cmd_data_q, cmd_data_d;
  logic          bus_en_q, bus_en_d;
  logic [2:0]    bus_sel_q, bus_sel_d;
  logic [7:0]    bus_data_q, bus_data_d;
  logic [7:0]    err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic          frame_done, frame_ok, good_frame, bad_frame, consume, drop_frame;
  logic [1:0]    ack_lost;
  logic [8:0]    drop_sum;

  // Frame parser with inter-byte timeout
  always_comb begin
    pstate_d   = pstate_q;
    sel_d      = sel_q;
    data_d     = data_q;
    idle_d     = idle_q;
    frame_done = 1'b0;
    if (rx_valid) begin
      idle_d = '0;
      case (pstate_q)
        P_HUNT:  if (rx_data == HDR_BYTE) pstate_d = P_GOT_H;
        P_GOT_H: begin sel_d = rx_data;  pstate_d = P_GOT_S; end
        P_GOT_S: begin data_d = rx_data; pstate_d = P_GOT_D; end
        P_GOT_D: begin frame_done = 1'b1; pstate_d = P_HUNT; end
        default: pstate_d = P_HUNT;
      endcase
    end else if (pstate_q != P_HUNT) begin
      if (idle_q == TW'(TIMEOUT_CYC)) begin
        pstate_d = P_HUNT;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    frame_ok   = (rx_data == (HDR_BYTE ^ sel_q ^ data_q)) && (sel_q[7:3] == 5'd0) &&
                 (sel_q[2:0] != 3'd0) && (sel_q[2:0] != 3'd7);
    good_frame = frame_done & frame_ok;
    bad_frame  = frame_done & ~frame_ok;
  end

  // Bus sequencer; outputs are decoded from the current state and registered
  always_comb begin
    bstate_d   = bstate_q;
    phase_d    = phase_q;
    consume    = 1'b0;
    cmd_sel_d  = cmd_sel_q;
    cmd_data_d = cmd_data_q;
    case (bstate_q)
      B_IDLE: begin
        phase_d = '0;
        if (pend_v_q) begin
          consume    = 1'b1;
          cmd_sel_d  = pend_sel_q;
          cmd_data_d = pend_data_q;
          bstate_d   = B_PRE;
        end
      end
      B_PRE: begin
        bstate_d = B_LOAD;
        phase_d  = '0;
      end
      B_LOAD: begin
        if (phase_q == 8'(SETUP_CYC - 1)) begin bstate_d = B_HOLD; phase_d = '0; end
        else phase_d = phase_q + 8'd1;
      end
      B_HOLD: begin
        if (phase_q == 8'(HOLD_CYC - 1)) begin bstate_d = B_COMMIT; phase_d = '0; end
        else phase_d = phase_q + 8'd1;
      end
      B_COMMIT: begin
        if (phase_q == 8'(COMMIT_CYC - 1)) begin bstate_d = B_IDLE; phase_d = '0; end
        else phase_d = phase_q + 8'd1;
      end
      default: bstate_d = B_IDLE;
    endcase

    bus_en_d   = 1'b1;
    bus_sel_d  = 3'd0;
    bus_data_d = 8'd0;
    case (bstate_q)
      B_PRE:  begin bus_sel_d = cmd_sel_q; bus_data_d = cmd_data_q; end
      B_LOAD: begin bus_en_d = 1'b0; bus_sel_d = cmd_sel_q; bus_data_d = cmd_data_q; end
      B_HOLD: begin bus_en_d = 1'b0; bus_data_d = cmd_data_q; end
      default: ;
    endcase
  end

  // Pending slot: a consume in the same cycle frees it for the arriving frame
  always_comb begin
    pend_v_d    = pend_v_q & ~consume;
    pend_sel_d  = pend_sel_q;
    pend_data_d = pend_data_q;
    drop_frame  = 1'b0;
    if (good_frame) begin
      if (pend_v_d) begin
        drop_frame = 1'b1;
      end else begin
        pend_v_d    = 1'b1;
        pend_sel_d  = sel_q[2:0];
        pend_data_d = data_q;
      end
    end
    err_cnt_d  = (bad_frame && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + {8'd0, drop_frame} + {7'd0, ack_lost};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q    <= P_HUNT;
      sel_q       <= '0;
      data_q      <= '0;
      idle_q      <= '0;
      bstate_q    <= B_IDLE;
      phase_q     <= '0;
      pend_v_q    <= 1'b0;
      pend_sel_q  <= '0;
      pend_data_q <= '0;
      cmd_sel_q   <= '0;
      cmd_data_q  <= '0;
      bus_en_q    <= 1'b1;
      bus_sel_q   <= '0;
      bus_data_q  <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pstate_q    <= pstate_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      idle_q      <= idle_d;
      bstate_q    <= bstate_d;
      phase_q     <= phase_d;
      pend_v_q    <= pend_v_d;
      pend_sel_q  <= pend_sel_d;
      pend_data_q <= pend_data_d;
      cmd_sel_q   <= cmd_sel_d;
      cmd_data_q  <= cmd_data_d;
      bus_en_q    <= bus_en_d;
      bus_sel_q   <= bus_sel_d;
      bus_data_q  <= bus_data_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef ACK_TX_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       commit_done;

  // A commit ack wins over a simultaneous reject ack; whatever does not fit is counted as dropped
  always_comb begin
    commit_done = (bstate_q == B_COMMIT) && (phase_q == 8'(COMMIT_CYC - 1));
    tx_valid_d  = tx_valid_q & ~tx_ready;
    tx_data_d   = tx_data_q;
    ack_lost    = {1'b0, commit_done} + {1'b0, bad_frame};
    if ((commit_done | bad_frame) && !tx_valid_d) begin
      tx_valid_d = 1'b1;
      tx_data_d  = commit_done ? 8'h5A : 8'hEE;
      ack_lost   = ack_lost - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`else
  assign ack_lost = 2'd0;
`endif

  assign bus_en   = bus_en_q;
  assign bus_sel  = bus_sel_q;
  assign bus_data = bus_data_q;
  assign busy     = (bstate_q != B_IDLE) | pend_v_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule
